// File: rtl/tcdm_tgen_pkg.sv
// =============================================================================
// tcdm_tgen_pkg: shared types and LFSR helpers for the TCDM traffic generator
// Rev 1.0
// =============================================================================
`default_nettype none

package tcdm_tgen_pkg;

    typedef enum logic [1:0] {
        UNIFORM = 2'd0,
        LINEAR  = 2'd1,
        HOTSPOT = 2'd2,
        RSVD    = 2'd3
    } tgen_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tgen_state_e;

    // Galois form of x^32 + x^22 + x^2 + x + 1 (maximal length)
    localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ c_LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [31:0] lfsr_seed(input logic [31:0] base, input logic [31:0] salt);
        logic [31:0] w_s;
        w_s = base ^ salt;
        return (w_s == 32'd0) ? 32'd1 : w_s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tcdm_tgen_channel.sv
// =============================================================================
// tcdm_tgen_channel: one generator lane (LFSR, request hold, address, checker, stats)
// Rev 1.0
// =============================================================================
`default_nettype none

module tcdm_tgen_channel
    import tcdm_tgen_pkg::*;
#(
    parameter int unsigned ChanIdx      = 0,
    parameter int unsigned NumMaster    = 64,
    parameter int unsigned NumBanks     = 128,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrMemWidth = 12,
    parameter int unsigned ProbWidth    = 10,
    parameter int unsigned CntWidth     = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        run_i,
    input  logic                        cnt_en_i,
    input  logic [1:0]                  mode_i,
    input  logic [ProbWidth:0]          req_prob_i,
    input  logic [ProbWidth:0]          wr_prob_i,
    input  logic [$clog2(NumBanks)-1:0] hot_bank_i,
    input  logic [31:0]                 seed_i,
    input  logic                        gnt_i,
    input  logic                        rvld_i,
    output logic                        req_o,
    output logic [AddrWidth-1:0]        add_o,
    output logic                        wen_o,
    output logic [DataWidth-1:0]        wdata_o,
    output logic [CntWidth-1:0]         req_cnt_o,
    output logic [CntWidth-1:0]         gnt_cnt_o,
    output logic [CntWidth-1:0]         wait_cnt_o,
    output logic [CntWidth-1:0]         err_cnt_o
);

    localparam int unsigned c_BANK_BITS = $clog2(NumBanks);
    localparam int unsigned c_BYTE_OFF  = $clog2(DataWidth / 8);
    localparam int unsigned c_WORD_BITS = c_BANK_BITS + AddrMemWidth;
    localparam logic [c_WORD_BITS-1:0] c_LIN_START = c_WORD_BITS'(ChanIdx * NumBanks / NumMaster);
    localparam logic [31:0] c_SEED_SALT = 32'(ChanIdx + 1);

    logic [31:0]            lfsr_q;
    logic                   req_q, wen_q, exp_q;
    logic [AddrWidth-1:0]   add_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [c_WORD_BITS-1:0] lin_q;
    logic [CntWidth-1:0]    req_cnt_q, gnt_cnt_q, wait_cnt_q, err_cnt_q;

    logic                   w_grant, w_free, w_req_hit, w_wr_hit;
    logic [c_WORD_BITS-1:0] w_rnd_word, w_word;
    logic [AddrWidth-1:0]   w_add;
    logic [DataWidth-1:0]   w_wdata;

    assign w_grant   = req_q & gnt_i;
    assign w_free    = ~req_q | gnt_i;
    assign w_req_hit = {1'b0, lfsr_q[ProbWidth-1:0]} < req_prob_i;
    assign w_wr_hit  = {1'b0, lfsr_q[16 +: ProbWidth]} < wr_prob_i;

    // Address bits mix two disjoint LFSR taps so they decorrelate from the draws
    always_comb begin
        w_rnd_word = '0;
        for (int i = 0; i < int'(c_WORD_BITS); i++) begin
            w_rnd_word[i] = lfsr_q[5'((i * 7 + 3) % 32)] ^ lfsr_q[5'((i * 13 + 20) % 32)];
        end
        w_wdata = '0;
        for (int i = 0; i < int'(DataWidth); i++) begin
            w_wdata[i] = lfsr_q[5'(i % 32)];
        end
    end

    // A linear request drawn in the granting cycle already targets the next word
    always_comb begin
        case (tgen_mode_e'(mode_i))
            LINEAR:  w_word = w_grant ? (lin_q + c_WORD_BITS'(1)) : lin_q;
            HOTSPOT: w_word = {w_rnd_word[c_WORD_BITS-1:c_BANK_BITS], hot_bank_i};
            default: w_word = w_rnd_word;
        endcase
        w_add = '0;
        w_add[c_BYTE_OFF +: c_WORD_BITS] = w_word;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q     <= 32'd1;
            req_q      <= 1'b0;
            wen_q      <= 1'b0;
            exp_q      <= 1'b0;
            add_q      <= '0;
            wdata_q    <= '0;
            lin_q      <= '0;
            req_cnt_q  <= '0;
            gnt_cnt_q  <= '0;
            wait_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (clear_i) begin
            lfsr_q     <= lfsr_seed(seed_i, c_SEED_SALT);
            req_q      <= 1'b0;
            wen_q      <= 1'b0;
            exp_q      <= 1'b0;
            lin_q      <= c_LIN_START;
            req_cnt_q  <= '0;
            gnt_cnt_q  <= '0;
            wait_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            exp_q <= w_grant;
            if (run_i) begin
                lfsr_q <= lfsr_step(lfsr_q);
            end
            if (w_grant) begin
                lin_q <= lin_q + c_WORD_BITS'(1);
            end
            if (w_free) begin
                if (run_i && w_req_hit) begin
                    req_q   <= 1'b1;
                    wen_q   <= w_wr_hit;
                    add_q   <= w_add;
                    wdata_q <= w_wdata;
                end else begin
                    req_q <= 1'b0;
                    wen_q <= 1'b0;
                end
            end
            if (cnt_en_i) begin
                if (req_q && (req_cnt_q != '1)) begin
                    req_cnt_q <= req_cnt_q + 1'b1;
                end
                if (w_grant && (gnt_cnt_q != '1)) begin
                    gnt_cnt_q <= gnt_cnt_q + 1'b1;
                end
                if (req_q && !gnt_i && (wait_cnt_q != '1)) begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
                if ((exp_q != rvld_i) && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end
        end
    end

    assign req_o      = req_q;
    assign add_o      = add_q;
    assign wen_o      = wen_q;
    assign wdata_o    = wdata_q;
    assign req_cnt_o  = req_cnt_q;
    assign gnt_cnt_o  = gnt_cnt_q;
    assign wait_cnt_o = wait_cnt_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

`default_nettype wire

// File: rtl/tcdm_traffic_gen.sv
// =============================================================================
// tcdm_traffic_gen: multi-master TCDM traffic generator and response checker
// Rev 1.0
// =============================================================================
`default_nettype none

module tcdm_traffic_gen
    import tcdm_tgen_pkg::*;
#(
    parameter int unsigned NumMaster    = 64,
    parameter int unsigned NumBanks     = 128,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrMemWidth = 12,
    parameter int unsigned ProbWidth    = 10,
    parameter int unsigned CntWidth     = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [31:0]                      num_cycles_i,
    input  logic [1:0]                       mode_i,
    input  logic [ProbWidth:0]               req_prob_i,
    input  logic [ProbWidth:0]               wr_prob_i,
    input  logic [$clog2(NumBanks)-1:0]      hot_bank_i,
    input  logic [31:0]                      seed_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [NumMaster-1:0]             req_o,
    output logic [NumMaster*AddrWidth-1:0]   add_o,
    output logic [NumMaster-1:0]             wen_o,
    output logic [NumMaster*DataWidth-1:0]   wdata_o,
    output logic [NumMaster*DataWidth/8-1:0] be_o,
    input  logic [NumMaster-1:0]             gnt_i,
    input  logic [NumMaster-1:0]             rvld_i,
    output logic [NumMaster*CntWidth-1:0]    req_cnt_o,
    output logic [NumMaster*CntWidth-1:0]    gnt_cnt_o,
    output logic [NumMaster*CntWidth-1:0]    wait_cnt_o,
    output logic [NumMaster*CntWidth-1:0]    err_cnt_o
);

    tgen_state_e state_q;
    logic [31:0] cyc_q;
    logic [1:0]  mode_q;
    logic        busy_q, done_q;

    logic [NumMaster-1:0] w_req;
    logic                 w_clear, w_run, w_drained;

    assign w_clear   = (state_q == IDLE) && start_i;
    assign w_run     = (state_q == RUN);
    assign w_drained = ~|w_req;

    // Grants in the last DRAIN cycle are still checked there, so an empty
    // request vector is enough to declare the drain complete.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cyc_q   <= 32'd0;
            mode_q  <= UNIFORM;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q  <= mode_i;
                        cyc_q   <= num_cycles_i;
                        busy_q  <= 1'b1;
                        state_q <= (num_cycles_i == 32'd0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    cyc_q <= cyc_q - 32'd1;
                    if (cyc_q <= 32'd1) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar m = 0; m < NumMaster; m++) begin : g_chan
        tcdm_tgen_channel #(
            .ChanIdx      (m),
            .NumMaster    (NumMaster),
            .NumBanks     (NumBanks),
            .AddrWidth    (AddrWidth),
            .DataWidth    (DataWidth),
            .AddrMemWidth (AddrMemWidth),
            .ProbWidth    (ProbWidth),
            .CntWidth     (CntWidth)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (w_clear),
            .run_i      (w_run),
            .cnt_en_i   (busy_q),
            .mode_i     (mode_q),
            .req_prob_i (req_prob_i),
            .wr_prob_i  (wr_prob_i),
            .hot_bank_i (hot_bank_i),
            .seed_i     (seed_i),
            .gnt_i      (gnt_i[m]),
            .rvld_i     (rvld_i[m]),
            .req_o      (w_req[m]),
            .add_o      (add_o[m*AddrWidth +: AddrWidth]),
            .wen_o      (wen_o[m]),
            .wdata_o    (wdata_o[m*DataWidth +: DataWidth]),
            .req_cnt_o  (req_cnt_o[m*CntWidth +: CntWidth]),
            .gnt_cnt_o  (gnt_cnt_o[m*CntWidth +: CntWidth]),
            .wait_cnt_o (wait_cnt_o[m*CntWidth +: CntWidth]),
            .err_cnt_o  (err_cnt_o[m*CntWidth +: CntWidth])
        );
    end

    assign req_o  = w_req;
    assign be_o   = '1;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tcdm_traffic_gen.sv
// =============================================================================
// tb_tcdm_traffic_gen: randomized bench with a protocol-level responder and scoreboard
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_tcdm_traffic_gen;

    localparam int NM = 4, NB = 16, AW = 32, DW = 32, AMW = 2, PW = 10, CW = 8;
    localparam int WORDS = NB * (1 << AMW);
    localparam int SAT = (1 << CW) - 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i = 1'b0;
    logic [31:0]       num_cycles_i = '0;
    logic [1:0]        mode_i = '0;
    logic [PW:0]       req_prob_i = '0, wr_prob_i = '0;
    logic [3:0]        hot_bank_i = '0;
    logic [31:0]       seed_i = '0;
    logic              busy_o, done_o;
    logic [NM-1:0]     req_o, wen_o;
    logic [NM*AW-1:0]  add_o;
    logic [NM*DW-1:0]  wdata_o;
    logic [NM*DW/8-1:0] be_o;
    logic [NM-1:0]     gnt_i = '0, rvld_i = '0;
    logic [NM*CW-1:0]  req_cnt_o, gnt_cnt_o, wait_cnt_o, err_cnt_o;

    always #5 clk_i = ~clk_i;

    tcdm_traffic_gen #(
        .NumMaster(NM), .NumBanks(NB), .AddrWidth(AW), .DataWidth(DW),
        .AddrMemWidth(AMW), .ProbWidth(PW), .CntWidth(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .num_cycles_i(num_cycles_i),
        .mode_i(mode_i), .req_prob_i(req_prob_i), .wr_prob_i(wr_prob_i),
        .hot_bank_i(hot_bank_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
        .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
        .gnt_i(gnt_i), .rvld_i(rvld_i), .req_cnt_o(req_cnt_o), .gnt_cnt_o(gnt_cnt_o),
        .wait_cnt_o(wait_cnt_o), .err_cnt_o(err_cnt_o)
    );

    int vectors = 0, miscompares = 0;

    // Scoreboard: transaction counts observed on the bus plus rule violations
    int exp_req[NM], exp_gnt[NM], exp_wait[NM], exp_err[NM], lin_exp[NM];
    int fmt_viol, hold_viol, hot_viol, wen_viol, lin_viol, done_cnt;
    bit gnt_rand, chk_hot, chk_nowr, chk_lin, saw_top, wrap_seen;
    int stall0;
    bit [NM-1:0] drop_pend, inj_pend, prev_gnt, pend;
    logic [31:0] held_a[NM], held_d[NM];
    logic held_w[NM];

    // Responder: grants chosen on the falling edge apply to the current cycle,
    // responses follow the previous cycle's grants unless a fault is requested.
    always @(negedge clk_i) begin
        logic [NM-1:0] g, r;
        logic [31:0] a;
        g = gnt_rand ? NM'($urandom) : '1;
        if (stall0 > 0 && req_o[0]) begin
            g[0] = 1'b0;
            stall0--;
        end
        r = prev_gnt;
        if (busy_o) begin
            if (done_o) done_cnt++;
            for (int m = 0; m < NM; m++) begin
                if (drop_pend[m] && prev_gnt[m]) begin
                    r[m] = 1'b0; drop_pend[m] = 1'b0; exp_err[m]++;
                end else if (inj_pend[m] && !prev_gnt[m]) begin
                    r[m] = 1'b1; inj_pend[m] = 1'b0; exp_err[m]++;
                end
                if (chk_nowr && wen_o[m]) wen_viol++;
                if (pend[m] && !req_o[m]) hold_viol++;
                if (req_o[m]) begin
                    a = add_o[m*AW +: AW];
                    exp_req[m]++;
                    if (g[m]) exp_gnt[m]++; else exp_wait[m]++;
                    if (a[1:0] != 2'b00 || a[31:8] != 24'd0) fmt_viol++;
                    if (chk_hot && a[5:2] != hot_bank_i) hot_viol++;
                    if (pend[m] && (a != held_a[m] || wen_o[m] != held_w[m] ||
                                    wdata_o[m*DW +: DW] != held_d[m])) hold_viol++;
                    if (chk_lin && !pend[m]) begin
                        if (a != 32'(lin_exp[m] * 4)) lin_viol++;
                        if (m == 1 && lin_exp[m] == WORDS - 1) saw_top = 1'b1;
                        if (m == 1 && lin_exp[m] == 0 && saw_top) wrap_seen = 1'b1;
                    end
                    if (chk_lin && g[m]) lin_exp[m] = (lin_exp[m] + 1) % WORDS;
                end
            end
        end else if (done_o) begin
            done_cnt++;
        end
        gnt_i = g;
        rvld_i = r;
        prev_gnt = req_o & g;
        pend = req_o & ~g;
        for (int m = 0; m < NM; m++) begin
            held_a[m] = add_o[m*AW +: AW];
            held_d[m] = wdata_o[m*DW +: DW];
            held_w[m] = wen_o[m];
        end
    end

    task automatic clear_model();
        for (int m = 0; m < NM; m++) begin
            exp_req[m] = 0; exp_gnt[m] = 0; exp_wait[m] = 0; exp_err[m] = 0;
            lin_exp[m] = m * NB / NM;
        end
        fmt_viol = 0; hold_viol = 0; hot_viol = 0; wen_viol = 0; lin_viol = 0;
        saw_top = 0; wrap_seen = 0; pend = '0; prev_gnt = '0;
    endtask

    task automatic start_run(input int n, input int mode, input int rp, input int wp, input int hot);
        @(posedge clk_i); #1;
        clear_model();
        num_cycles_i = 32'(n); mode_i = 2'(mode); req_prob_i = (PW+1)'(rp);
        wr_prob_i = (PW+1)'(wp); hot_bank_i = 4'(hot); seed_i = $urandom;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (!done_o && edges < budget) begin
            @(posedge clk_i); #1;
            edges++;
        end
        if (!done_o) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout got busy=%0b after %0d cycles, required done_o=1", busy_o, edges);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if ({req_o, wen_o, busy_o, done_o} !== '0 || add_o !== '0 || wdata_o !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got req=%h wen=%h busy=%b done=%b add=%h, required all 0",
                     req_o, wen_o, busy_o, done_o, add_o);
        end
        vectors++;
        if (be_o !== '1 || req_cnt_o !== '0 || gnt_cnt_o !== '0 || wait_cnt_o !== '0 || err_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL reset_be_cnt got be=%h req_cnt=%h err_cnt=%h, required be all ones and counters 0",
                     be_o, req_cnt_o, err_cnt_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_full_rate();
        int edges;
        gnt_rand = 0; stall0 = 0; chk_hot = 0; chk_nowr = 0; chk_lin = 0;
        start_run(100, 0, 1 << PW, $urandom_range(0, 1 << PW), 0);
        wait_done(300, edges);
        vectors++;
        if (edges < 101 || edges > 103) begin
            miscompares++;
            $display("FAIL full_rate_latency got %0d cycles to done, required 101..103", edges);
        end
        for (int m = 0; m < NM; m++) begin
            vectors++;
            if (req_cnt_o[m*CW +: CW] !== 8'd100 || gnt_cnt_o[m*CW +: CW] !== 8'd100 ||
                wait_cnt_o[m*CW +: CW] !== 8'd0 || err_cnt_o[m*CW +: CW] !== 8'd0) begin
                miscompares++;
                $display("FAIL full_rate_m%0d got req=%0d gnt=%0d wait=%0d err=%0d, required 100/100/0/0", m,
                         req_cnt_o[m*CW +: CW], gnt_cnt_o[m*CW +: CW], wait_cnt_o[m*CW +: CW], err_cnt_o[m*CW +: CW]);
            end
        end
    endtask

    task automatic test_saturation();
        int edges;
        gnt_rand = 0; stall0 = 0;
        start_run(300, 0, 1 << PW, 0, 0);
        wait_done(400, edges);
        for (int m = 0; m < NM; m++) begin
            vectors++;
            if (req_cnt_o[m*CW +: CW] !== CW'(SAT) || gnt_cnt_o[m*CW +: CW] !== CW'(SAT) ||
                wait_cnt_o[m*CW +: CW] !== '0) begin
                miscompares++;
                $display("FAIL saturate_m%0d got req=%0d gnt=%0d wait=%0d, required %0d/%0d/0", m,
                         req_cnt_o[m*CW +: CW], gnt_cnt_o[m*CW +: CW], wait_cnt_o[m*CW +: CW], SAT, SAT);
            end
        end
    endtask

    task automatic test_stall();
        int edges;
        gnt_rand = 0; stall0 = 5;
        start_run(20, 0, 1 << PW, 1 << (PW - 1), 0);
        wait_done(100, edges);
        vectors++;
        if (wait_cnt_o[0 +: CW] !== 8'd5 || hold_viol != 0) begin
            miscompares++;
            $display("FAIL stall_hold got wait_cnt0=%0d hold_violations=%0d, required 5 and 0",
                     wait_cnt_o[0 +: CW], hold_viol);
        end
        vectors++;
        if (gnt_cnt_o[0 +: CW] !== CW'(exp_gnt[0]) || req_cnt_o[0 +: CW] !== CW'(exp_req[0])) begin
            miscompares++;
            $display("FAIL stall_counts got gnt=%0d req=%0d, required %0d/%0d",
                     gnt_cnt_o[0 +: CW], req_cnt_o[0 +: CW], exp_gnt[0], exp_req[0]);
        end
    endtask

    task automatic test_linear();
        int edges;
        gnt_rand = 0; stall0 = 0; chk_lin = 1;
        start_run(80, 1, 1 << PW, 0, 0);
        wait_done(200, edges);
        chk_lin = 0;
        vectors++;
        if (lin_viol != 0 || fmt_viol != 0) begin
            miscompares++;
            $display("FAIL linear_addr got %0d sequence and %0d format violations, required 0", lin_viol, fmt_viol);
        end
        vectors++;
        if (!wrap_seen) begin
            miscompares++;
            $display("FAIL linear_wrap got no wrap to 0 on master1, required wrap after word %0d", WORDS - 1);
        end
    endtask

    task automatic test_hotspot();
        int edges;
        gnt_rand = 1; stall0 = 0; chk_hot = 1; chk_nowr = 1;
        start_run(200, 2, $urandom_range(300, 1 << PW), 0, 7);
        wait_done(400, edges);
        chk_hot = 0; chk_nowr = 0;
        vectors++;
        if (hot_viol != 0 || wen_viol != 0 || hold_viol != 0) begin
            miscompares++;
            $display("FAIL hotspot got bank_viol=%0d wen_viol=%0d hold_viol=%0d, required 0",
                     hot_viol, wen_viol, hold_viol);
        end
        for (int m = 0; m < NM; m++) begin
            vectors++;
            if (req_cnt_o[m*CW +: CW] !== CW'(exp_req[m] > SAT ? SAT : exp_req[m]) ||
                wait_cnt_o[m*CW +: CW] !== CW'(exp_wait[m] > SAT ? SAT : exp_wait[m])) begin
                miscompares++;
                $display("FAIL hotspot_cnt_m%0d got req=%0d wait=%0d, required %0d/%0d", m,
                         req_cnt_o[m*CW +: CW], wait_cnt_o[m*CW +: CW], exp_req[m], exp_wait[m]);
            end
        end
    endtask

    task automatic test_random_uniform();
        int edges, mode;
        gnt_rand = 1; stall0 = 0;
        for (int it = 0; it < 4; it++) begin
            mode = (it % 2 == 0) ? 0 : 3;
            start_run($urandom_range(20, 120), mode, $urandom_range(0, 1 << PW),
                      $urandom_range(0, 1 << PW), 0);
            wait_done(300, edges);
            vectors++;
            if (fmt_viol != 0 || hold_viol != 0) begin
                miscompares++;
                $display("FAIL uniform_it%0d got fmt_viol=%0d hold_viol=%0d, required 0", it, fmt_viol, hold_viol);
            end
            for (int m = 0; m < NM; m++) begin
                vectors++;
                if (req_cnt_o[m*CW +: CW] !== CW'(exp_req[m] > SAT ? SAT : exp_req[m]) ||
                    gnt_cnt_o[m*CW +: CW] !== CW'(exp_gnt[m] > SAT ? SAT : exp_gnt[m]) ||
                    wait_cnt_o[m*CW +: CW] !== CW'(exp_wait[m] > SAT ? SAT : exp_wait[m]) ||
                    err_cnt_o[m*CW +: CW] !== 8'd0) begin
                    miscompares++;
                    $display("FAIL uniform_it%0d_m%0d got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/0", it, m,
                             req_cnt_o[m*CW +: CW], gnt_cnt_o[m*CW +: CW], wait_cnt_o[m*CW +: CW],
                             err_cnt_o[m*CW +: CW], exp_req[m], exp_gnt[m], exp_wait[m]);
                end
            end
        end
    endtask

    task automatic test_errors();
        int edges;
        gnt_rand = 1; stall0 = 0;
        drop_pend = 4'b0100; inj_pend = 4'b0100;
        start_run(60, 0, 1 << PW, 1 << (PW - 1), 0);
        wait_done(200, edges);
        for (int m = 0; m < NM; m++) begin
            vectors++;
            if (err_cnt_o[m*CW +: CW] !== ((m == 2) ? 8'd2 : 8'd0)) begin
                miscompares++;
                $display("FAIL err_cnt_m%0d got %0d, required %0d", m, err_cnt_o[m*CW +: CW], (m == 2) ? 2 : 0);
            end
        end
        drop_pend = '0; inj_pend = '0;
    endtask

    task automatic test_idle_and_reset();
        int edges, d0;
        gnt_rand = 1; stall0 = 0;
        start_run(50, 0, 0, 1 << PW, 0);
        wait_done(100, edges);
        vectors++;
        if (req_cnt_o !== '0 || (exp_req[0] + exp_req[1] + exp_req[2] + exp_req[3]) != 0) begin
            miscompares++;
            $display("FAIL req_prob_zero got req_cnt=%h observed_reqs=%0d, required 0", req_cnt_o,
                     exp_req[0] + exp_req[1] + exp_req[2] + exp_req[3]);
        end
        start_run(200, 0, 1 << PW, 1 << PW, 0);
        repeat (10) @(posedge clk_i);
        #1;
        d0 = done_cnt;
        rst_ni = 1'b0;
        #1;
        vectors++;
        if (req_o !== '0 || busy_o !== 1'b0 || add_o !== '0 || wen_o !== '0 || req_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset got req=%h busy=%b add=%h req_cnt=%h, required 0",
                     req_o, busy_o, add_o, req_cnt_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        vectors++;
        if (done_cnt != d0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_no_done got %0d done pulses busy=%b, required 0 and idle", done_cnt - d0, busy_o);
        end
        start_run(0, 0, 1 << PW, 0, 0);
        wait_done(2, edges);
        vectors++;
        if (edges > 2 || req_cnt_o !== '0) begin
            miscompares++;
            $display("FAIL zero_cycles got done after %0d cycles req_cnt=%h, required <=2 and 0", edges, req_cnt_o);
        end
    endtask

    initial begin
        clear_model();
        done_cnt = 0; gnt_rand = 0; stall0 = 0; chk_hot = 0; chk_nowr = 0; chk_lin = 0;
        drop_pend = '0; inj_pend = '0;
        test_reset();
        test_full_rate();
        test_saturation();
        test_stall();
        test_linear();
        test_hotspot();
        test_random_uniform();
        test_errors();
        test_idle_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
